// File: rtl/dco_tune_encoder_if.sv
// Tuning-word handshake between the ADPLL loop filter/FSM (master) and the
// DCO tune encoder (slave): one valid/ready pair plus the three bank targets.
interface dco_tune_encoder_if;
    logic       tune_valid;
    logic       tune_ready;
    logic [4:0] tune_l;
    logic [8:0] tune_m;
    logic [8:0] tune_s;

    modport master (
        output tune_valid,
        output tune_l,
        output tune_m,
        output tune_s,
        input  tune_ready
    );

    modport slave (
        input  tune_valid,
        input  tune_l,
        input  tune_m,
        input  tune_s,
        output tune_ready
    );
endinterface

// File: rtl/dco_tune_encoder.sv
// DCO capacitor-bank front end: clamps binary L/M/S tuning words, slews each
// bank code toward its target in bounded steps and drives registered r_all/row/col matrix selects.
module dco_tune_encoder #(
    parameter int unsigned RST_L      = 12,
    parameter int unsigned RST_M      = 128,
    parameter int unsigned RST_S      = 128,
    parameter int unsigned MAX_STEP_L = 1,
    parameter int unsigned MAX_STEP_M = 16,
    parameter int unsigned MAX_STEP_S = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    dco_tune_encoder_if.slave         tune,
    output logic [4:0]                c_l_r_all,
    output logic [4:0]                c_l_row,
    output logic [4:0]                c_l_col,
    output logic [15:0]               c_m_r_all,
    output logic [15:0]               c_m_row,
    output logic [15:0]               c_m_col,
    output logic [15:0]               c_s_r_all,
    output logic [15:0]               c_s_row,
    output logic [15:0]               c_s_col,
    output logic                      sat,
    output logic                      upd_done
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SLEW = 1'b1
    } state_t;

    typedef struct packed {
        logic [4:0] r_all;
        logic [4:0] row;
        logic [4:0] col;
    } enc_l_t;

    typedef struct packed {
        logic [15:0] r_all;
        logic [15:0] row;
        logic [15:0] col;
    } enc_ms_t;

    localparam logic [4:0] MAX_CODE_L = 5'd25;
    localparam logic [8:0] MAX_CODE_MS = 9'd256;

    localparam logic [9:0] STEP_L = 10'(MAX_STEP_L);
    localparam logic [9:0] STEP_M = 10'(MAX_STEP_M);
    localparam logic [9:0] STEP_S = 10'(MAX_STEP_S);

    localparam logic [4:0] INIT_L = 5'(RST_L);
    localparam logic [8:0] INIT_M = 9'(RST_M);
    localparam logic [8:0] INIT_S = 9'(RST_S);

    // 5x5 L array: F = N/5 full rows, P = N%5 cells in the partial row.
    function automatic enc_l_t encode_l(input logic [4:0] n);
        enc_l_t     e;
        logic [2:0] f;
        logic [2:0] p;
        f       = 3'(n / 5'd5);
        p       = 3'(n % 5'd5);
        e.r_all = 5'((6'd1 << f) - 6'd1);
        e.col   = 5'((6'd1 << p) - 6'd1);
        e.row   = (p != 3'd0) ? 5'(6'd1 << f) : 5'd0;
        return e;
    endfunction

    // 16x16 M/S arrays: the divide by 16 is just the upper/lower code bits.
    function automatic enc_ms_t encode_ms(input logic [8:0] n);
        enc_ms_t    e;
        logic [4:0] f;
        logic [3:0] p;
        f       = n[8:4];
        p       = n[3:0];
        e.r_all = 16'((17'd1 << f) - 17'd1);
        e.col   = 16'((17'd1 << p) - 17'd1);
        e.row   = (p != 4'd0) ? 16'(17'd1 << f) : 16'd0;
        return e;
    endfunction

    // One slew step; a zero step limit jumps straight to the target.
    function automatic logic [8:0] slew(input logic [8:0] cur,
                                        input logic [8:0] tgt,
                                        input logic [9:0] max_step);
        logic signed [9:0] diff;
        logic        [9:0] mag;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        mag  = diff[9] ? 10'(-diff) : 10'(diff);
        if ((max_step == 10'd0) || (mag <= max_step))
            return tgt;
        else if (diff[9])
            return cur - max_step[8:0];
        else
            return cur + max_step[8:0];
    endfunction

    state_t     r_state;
    state_t     w_next_state;

    logic [4:0] r_code_l;
    logic [8:0] r_code_m;
    logic [8:0] r_code_s;
    logic [4:0] r_tgt_l;
    logic [8:0] r_tgt_m;
    logic [8:0] r_tgt_s;

    enc_l_t     r_enc_l;
    enc_ms_t    r_enc_m;
    enc_ms_t    r_enc_s;
    logic       r_sat;
    logic       r_upd_done;

    logic       w_accept;
    logic       w_step;
    logic       w_sat;
    logic       w_upd_done;
    logic       w_all_done;
    logic [4:0] w_tgt_l;
    logic [8:0] w_tgt_m;
    logic [8:0] w_tgt_s;
    logic [4:0] w_code_l;
    logic [8:0] w_code_m;
    logic [8:0] w_code_s;

    assign tune.tune_ready = en & (r_state == ST_IDLE);
    assign w_accept        = tune.tune_valid & tune.tune_ready;
    assign w_step          = en & ((r_state == ST_SLEW) | w_accept);

    assign w_sat = w_accept & ((tune.tune_l > MAX_CODE_L) |
                               (tune.tune_m > MAX_CODE_MS) |
                               (tune.tune_s > MAX_CODE_MS));

    // The accept edge already steps toward the freshly clamped targets.
    assign w_tgt_l = !w_accept ? r_tgt_l :
                     (tune.tune_l > MAX_CODE_L) ? MAX_CODE_L : tune.tune_l;
    assign w_tgt_m = !w_accept ? r_tgt_m :
                     (tune.tune_m > MAX_CODE_MS) ? MAX_CODE_MS : tune.tune_m;
    assign w_tgt_s = !w_accept ? r_tgt_s :
                     (tune.tune_s > MAX_CODE_MS) ? MAX_CODE_MS : tune.tune_s;

    assign w_code_l = w_step ? 5'(slew({4'd0, r_code_l}, {4'd0, w_tgt_l}, STEP_L)) : r_code_l;
    assign w_code_m = w_step ? slew(r_code_m, w_tgt_m, STEP_M) : r_code_m;
    assign w_code_s = w_step ? slew(r_code_s, w_tgt_s, STEP_S) : r_code_s;

    assign w_all_done = (w_code_l == w_tgt_l) & (w_code_m == w_tgt_m) & (w_code_s == w_tgt_s);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_upd_done   = 1'b0;
        if (w_step) begin
            if (w_all_done) begin
                w_next_state = ST_IDLE;
                w_upd_done   = 1'b1;
            end else begin
                w_next_state = ST_SLEW;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_code_l   <= INIT_L;
            r_code_m   <= INIT_M;
            r_code_s   <= INIT_S;
            r_tgt_l    <= INIT_L;
            r_tgt_m    <= INIT_M;
            r_tgt_s    <= INIT_S;
            r_enc_l    <= encode_l(INIT_L);
            r_enc_m    <= encode_ms(INIT_M);
            r_enc_s    <= encode_ms(INIT_S);
            r_sat      <= 1'b0;
            r_upd_done <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_tgt_l    <= w_tgt_l;
            r_tgt_m    <= w_tgt_m;
            r_tgt_s    <= w_tgt_s;
            r_code_l   <= w_code_l;
            r_code_m   <= w_code_m;
            r_code_s   <= w_code_s;
            r_enc_l    <= encode_l(w_code_l);
            r_enc_m    <= encode_ms(w_code_m);
            r_enc_s    <= encode_ms(w_code_s);
            r_sat      <= w_sat;
            r_upd_done <= w_upd_done;
        end
    end

    assign c_l_r_all = r_enc_l.r_all;
    assign c_l_row   = r_enc_l.row;
    assign c_l_col   = r_enc_l.col;
    assign c_m_r_all = r_enc_m.r_all;
    assign c_m_row   = r_enc_m.row;
    assign c_m_col   = r_enc_m.col;
    assign c_s_r_all = r_enc_s.r_all;
    assign c_s_row   = r_enc_s.row;
    assign c_s_col   = r_enc_s.col;
    assign sat       = r_sat;
    assign upd_done  = r_upd_done;

endmodule

// File: tb/tb_dco_tune_encoder.sv
// Scoreboard bench for dco_tune_encoder: the driver queues expected results per
// accepted word, a negedge monitor checks them whenever upd_done pulses.
module tb_dco_tune_encoder;

    localparam int RST_L      = 12;
    localparam int RST_M      = 128;
    localparam int RST_S      = 128;
    localparam int MAX_STEP_L = 1;
    localparam int MAX_STEP_M = 16;
    localparam int MAX_STEP_S = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [4:0]  c_l_r_all, c_l_row, c_l_col;
    logic [15:0] c_m_r_all, c_m_row, c_m_col;
    logic [15:0] c_s_r_all, c_s_row, c_s_col;
    logic        sat, upd_done;

    dco_tune_encoder_if tif ();

    dco_tune_encoder #(
        .RST_L(RST_L), .RST_M(RST_M), .RST_S(RST_S),
        .MAX_STEP_L(MAX_STEP_L), .MAX_STEP_M(MAX_STEP_M), .MAX_STEP_S(MAX_STEP_S)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tune(tif),
        .c_l_r_all(c_l_r_all), .c_l_row(c_l_row), .c_l_col(c_l_col),
        .c_m_r_all(c_m_r_all), .c_m_row(c_m_row), .c_m_col(c_m_col),
        .c_s_r_all(c_s_r_all), .c_s_row(c_s_row), .c_s_col(c_s_col),
        .sat(sat), .upd_done(upd_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoding written straight from the cell rules.
    task automatic ref_enc(input int n, input int rows, input int cols,
                           output logic [15:0] ra, output logic [15:0] rw, output logic [15:0] cl);
        int f, p;
        f  = n / cols;
        p  = n % cols;
        ra = '0; rw = '0; cl = '0;
        for (int k = 0; k < rows; k++) begin
            ra[k] = (k < f);
            rw[k] = (k == f) && (p != 0);
        end
        for (int j = 0; j < cols; j++) cl[j] = (j < p);
    endtask

    function automatic int cells_on(input logic [15:0] ra, input logic [15:0] rw,
                                    input logic [15:0] cl, input int rows, input int cols);
        int cnt = 0;
        for (int i = 0; i < rows; i++)
            for (int j = 0; j < cols; j++)
                if (ra[i] || (rw[i] && cl[j])) cnt++;
        return cnt;
    endfunction

    function automatic int clampv(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    function automatic int steps_needed(input int from, input int to, input int max_step);
        int d = (to > from) ? to - from : from - to;
        if (d == 0) return 0;
        if (max_step == 0) return 1;
        return (d + max_step - 1) / max_step;
    endfunction

    typedef struct {
        int l, m, s;
        bit sat;
        int cycles;
    } exp_t;

    exp_t exp_q[$];
    int   mdl_l = RST_L, mdl_m = RST_M, mdl_s = RST_S;

    // Monitor: outputs are stable at negedge; en/valid change only just after posedge.
    bit mon_busy = 0;
    int mon_cyc  = 0;
    int mon_sat  = 0;

    always @(negedge clk) begin
        logic [15:0] ra, rw, cl;
        exp_t        e;
        if (!rst_n) begin
            mon_busy = 0;
            mon_cyc  = 0;
            mon_sat  = 0;
        end else begin
            if (sat) mon_sat++;
            if (upd_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_upd_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    ref_enc(e.l, 5, 5, ra, rw, cl);
                    check("l_enc", {c_l_r_all, c_l_row, c_l_col}, {ra[4:0], rw[4:0], cl[4:0]});
                    check("l_cells", cells_on({11'd0, c_l_r_all}, {11'd0, c_l_row}, {11'd0, c_l_col}, 5, 5), e.l);
                    ref_enc(e.m, 16, 16, ra, rw, cl);
                    check("m_enc", {c_m_r_all, c_m_row, c_m_col}, {ra, rw, cl});
                    check("m_cells", cells_on(c_m_r_all, c_m_row, c_m_col, 16, 16), e.m);
                    ref_enc(e.s, 16, 16, ra, rw, cl);
                    check("s_enc", {c_s_r_all, c_s_row, c_s_col}, {ra, rw, cl});
                    check("s_cells", cells_on(c_s_r_all, c_s_row, c_s_col, 16, 16), e.s);
                    check("sat_pulses", mon_sat, e.sat);
                    check("latency", mon_cyc, e.cycles);
                end
                mon_sat  = 0;
                mon_busy = 0;
            end
            if (en && tif.tune_ready && tif.tune_valid) begin
                mon_busy = 1;
                mon_cyc  = 0;
            end
            if (en && mon_busy) mon_cyc++;
        end
    end

    task automatic send(input int l, input int m, input int s);
        int   n = 0;
        exp_t e;
        @(posedge clk); #1;
        en             = 1'b1;
        tif.tune_valid = 1'b1;
        tif.tune_l     = 5'(l);
        tif.tune_m     = 9'(m);
        tif.tune_s     = 9'(s);
        @(negedge clk);
        while (!tif.tune_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", (n < 300), 1);
        if (n < 300) begin
            e.l    = clampv(l, 25);
            e.m    = clampv(m, 256);
            e.s    = clampv(s, 256);
            e.sat  = (l > 25) || (m > 256) || (s > 256);
            e.cycles = 1;
            if (steps_needed(mdl_l, e.l, MAX_STEP_L) > e.cycles) e.cycles = steps_needed(mdl_l, e.l, MAX_STEP_L);
            if (steps_needed(mdl_m, e.m, MAX_STEP_M) > e.cycles) e.cycles = steps_needed(mdl_m, e.m, MAX_STEP_M);
            if (steps_needed(mdl_s, e.s, MAX_STEP_S) > e.cycles) e.cycles = steps_needed(mdl_s, e.s, MAX_STEP_S);
            mdl_l = e.l;
            mdl_m = e.m;
            mdl_s = e.s;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        tif.tune_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit toggle_en);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            if (toggle_en) en = ($urandom_range(0, 3) != 0);
            n++;
        end
        en = 1'b1;
        check("done_timeout", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [15:0] ra, rw, cl;
        ref_enc(RST_L, 5, 5, ra, rw, cl);
        check({tag, "_l"}, {c_l_r_all, c_l_row, c_l_col}, {ra[4:0], rw[4:0], cl[4:0]});
        ref_enc(RST_M, 16, 16, ra, rw, cl);
        check({tag, "_m"}, {c_m_r_all, c_m_row, c_m_col}, {ra, rw, cl});
        ref_enc(RST_S, 16, 16, ra, rw, cl);
        check({tag, "_s"}, {c_s_r_all, c_s_row, c_s_col}, {ra, rw, cl});
        check({tag, "_ready"}, tif.tune_ready, en);
        check({tag, "_sat"}, sat, 0);
        check({tag, "_upd_done"}, upd_done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tif.tune_valid = 1'b0;
        tif.tune_l     = '0;
        tif.tune_m     = '0;
        tif.tune_s     = '0;
        en             = 1'b1;
        rst_n          = 1'b0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        check("reset_l_r_all_lit", c_l_r_all, 5'h03);
        check("reset_l_row_lit", c_l_row, 5'h04);
        check("reset_m_r_all_lit", c_m_r_all, 16'h00FF);
        check_reset_outputs("reset");

        // Large jump: L slews 1/clk, M 16/clk, S jumps at once.
        send(25, 256, 0);
        check("ready_low_slew", tif.tune_ready, 0);
        wait_idle(0);

        // M trajectory 128 -> 200 in 16-code steps.
        send(25, 128, 128);
        wait_idle(0);
        send(25, 200, 0);
        for (int k = 1; k <= 5; k++) begin
            check("m_traj", cells_on(c_m_r_all, c_m_row, c_m_col, 16, 16),
                  (128 + 16 * k > 200) ? 200 : 128 + 16 * k);
            check("ready_traj", tif.tune_ready, (k == 5));
            if (k < 5) begin
                @(posedge clk); #1;
            end
        end
        wait_idle(0);

        // Out-of-range fields clamp and pulse sat.
        send(31, 300, 400);
        wait_idle(0);

        // Freeze mid-slew: M 256 -> 0, hold for 3 clk after 3 steps.
        send(25, 0, 256);
        repeat (2) begin
            @(posedge clk); #1;
        end
        en = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("freeze_m", cells_on(c_m_r_all, c_m_row, c_m_col, 16, 16), 256 - 3 * 16);
            check("freeze_ready", tif.tune_ready, 0);
            check("freeze_pulses", {sat, upd_done}, 2'b00);
        end
        en = 1'b1;
        wait_idle(0);

        // Asynchronous reset in the middle of a slew.
        send(12, 256, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        mdl_l = RST_L; mdl_m = RST_M; mdl_s = RST_S;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Sweep M through every code with random L/S companions.
        for (int v = 0; v <= 256; v++) begin
            send($urandom_range(0, 25), v, $urandom_range(0, 256));
            wait_idle(0);
        end

        // Random words including out-of-range fields and en dropouts.
        for (int t = 0; t < 40; t++) begin
            send($urandom_range(0, 31), $urandom_range(0, 511), $urandom_range(0, 511));
            if ($urandom_range(0, 1) == 1) wait_idle(1);
        end
        wait_idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
